// File: rtl/irq_capture_ctrl.sv
// rtl/irq_capture_ctrl.sv - interrupt request capture, masking and valid/ready ID presentation
module irq_capture_ctrl #(
   parameter int N    = 8,
   parameter int W    = 3,
   parameter bit EDGE = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_in,
   input  logic [N-1:0] mask,
   input  logic         irq_ready,
   input  logic         ovf_clr,
   output logic         irq_valid,
   output logic [W-1:0] irq_id,
   output logic [N-1:0] pending,
   output logic         overflow
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t       state_q;
   logic [N-1:0] req_q;
   logic [N-1:0] pending_q, pending_d;
   logic         ovf_q, ovf_d;
   logic         valid_q;
   logic [W-1:0] id_q;

   logic [N-1:0] set_vec;
   logic [N-1:0] clr_vec;
   logic [N-1:0] elig;
   logic [W-1:0] hi_idx;
   logic         ovf_event;

   // Request capture: rising edges (or levels) that should mark a line pending this cycle
   always_comb begin
      set_vec = EDGE ? (req_in & ~req_q) : req_in;
   end

   // Accepted ID clears its own pending bit; set_vec is OR-ed in after so a fresh request survives
   always_comb begin
      clr_vec = '0;
      if (valid_q && irq_ready) begin
         clr_vec[id_q] = 1'b1;
      end
      pending_d = (pending_q & ~clr_vec) | set_vec;
      ovf_event = |(set_vec & pending_q & ~clr_vec);
      ovf_d     = ovf_event ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   end

   // Highest-index eligible pending line wins, matching the downstream encoder ordering
   always_comb begin
      elig   = pending_q & mask;
      hi_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (elig[i]) begin
            hi_idx = W'(i);
         end
      end
   end

   // Request history, pending register and sticky overflow flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q     <= '0;
         pending_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         req_q     <= req_in;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   // Presentation FSM: latch an ID, hold it stable until the consumer takes it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         id_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (elig != '0) begin
                  id_q    <= hi_idx;
                  valid_q <= 1'b1;
                  state_q <= PRESENT;
               end else begin
                  valid_q <= 1'b0;
               end
            end
            PRESENT: begin
               if (irq_ready) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign irq_valid = valid_q;
   assign irq_id    = id_q;
   assign pending   = pending_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_irq_capture_ctrl.sv
// tb/tb_irq_capture_ctrl.sv - self-checking bench for irq_capture_ctrl
module tb_irq_capture_ctrl;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_in;
   logic [7:0] mask;
   logic       irq_ready;
   logic       ovf_clr;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic [7:0] pending;
   logic       overflow;

   int checks;
   int errors;

   typedef struct packed {
      logic       rst_n;
      logic [7:0] req;
      logic [7:0] mask;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [2:0] eid;
      logic [7:0] ep;
      logic       eo;
   } vec_t;

   typedef struct packed {
      logic       v;
      logic [2:0] id;
      logic [7:0] p;
      logic       o;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   irq_capture_ctrl #(.N(8), .W(3), .EDGE(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_in    (req_in),
      .mask      (mask),
      .irq_ready (irq_ready),
      .ovf_clr   (ovf_clr),
      .irq_valid (irq_valid),
      .irq_id    (irq_id),
      .pending   (pending),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, queue the expected post-edge outputs, then pop and compare
   task automatic step(input vec_t t, input int idx);
      exp_t e;
      rst_n     = t.rst_n;
      req_in    = t.req;
      mask      = t.mask;
      irq_ready = t.rdy;
      ovf_clr   = t.clr;
      exp_q.push_back(exp_t'{t.ev, t.eid, t.ep, t.eo});
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_empty step %0d", idx);
      end else begin
         e = exp_q.pop_front();
         if (irq_valid !== e.v) begin
            errors++;
            $display("FAIL irq_valid step %0d got %0b exp %0b", idx, irq_valid, e.v);
         end
         checks++;
         if (irq_id !== e.id) begin
            errors++;
            $display("FAIL irq_id step %0d got %0d exp %0d", idx, irq_id, e.id);
         end
         checks++;
         if (pending !== e.p) begin
            errors++;
            $display("FAIL pending step %0d got %02h exp %02h", idx, pending, e.p);
         end
         checks++;
         if (overflow !== e.o) begin
            errors++;
            $display("FAIL overflow step %0d got %0b exp %0b", idx, overflow, e.o);
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      req_in    = 8'h00;
      mask      = 8'hFF;
      irq_ready = 1'b0;
      ovf_clr   = 1'b0;

      //             rst  req    mask   rdy   clr   v     id    pend   ovf
      // reset with all lines high, then release: edge capture and first grant
      vecs.push_back(vec_t'{1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0});
      vecs.push_back(vec_t'{1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'hFF, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 8'hFF, 1'b0});
      // reset mid-handshake drops valid and discards pending
      vecs.push_back(vec_t'{1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0});
      // single pulse on line 3
      vecs.push_back(vec_t'{1'b1, 8'h08, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0});
      // priority order 7, 4, 2 with one idle bubble between grants
      vecs.push_back(vec_t'{1'b1, 8'h94, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd3, 8'h94, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h94, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd7, 8'h94, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h94, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd7, 8'h14, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h94, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd4, 8'h14, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h94, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd4, 8'h04, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h94, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h94, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0});
      // masking: line 7 masked off, only line 1 presented, then unmask
      vecs.push_back(vec_t'{1'b1, 8'h82, 8'h7F, 1'b1, 1'b0, 1'b0, 3'd2, 8'h82, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h82, 8'h7F, 1'b1, 1'b0, 1'b1, 3'd1, 8'h82, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h82, 8'h7F, 1'b1, 1'b0, 1'b0, 3'd1, 8'h80, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h82, 8'h7F, 1'b1, 1'b0, 1'b0, 3'd1, 8'h80, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h82, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h82, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0});
      vecs.push_back(vec_t'{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0});

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i], i);
      end

      // backpressure: ID 5 held while line 6 arrives and mask drops, then drained in order
      step(vec_t'{1'b1, 8'h20, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd7, 8'h20, 1'b0}, 100);
      step(vec_t'{1'b1, 8'h20, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0}, 101);
      step(vec_t'{1'b1, 8'h60, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd5, 8'h60, 1'b0}, 102);
      step(vec_t'{1'b1, 8'h60, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h60, 1'b0}, 103);
      step(vec_t'{1'b1, 8'h60, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd5, 8'h40, 1'b0}, 104);
      step(vec_t'{1'b1, 8'h60, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0}, 105);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 1'b0}, 106);

      // overflow on a re-arriving pending line, then clear
      step(vec_t'{1'b1, 8'h04, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd6, 8'h04, 1'b0}, 200);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0}, 201);
      step(vec_t'{1'b1, 8'h04, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1}, 202);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1}, 203);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 1'b0}, 204);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0}, 205);

      // set beats clear: line 4 re-arrives on the edge its ID is accepted
      step(vec_t'{1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd2, 8'h10, 1'b0}, 300);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0}, 301);
      step(vec_t'{1'b1, 8'h10, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd4, 8'h10, 1'b0}, 302);
      step(vec_t'{1'b1, 8'h10, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0}, 303);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0}, 304);

      // overflow event and ovf_clr on the same edge: overflow stays set
      step(vec_t'{1'b1, 8'h04, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd4, 8'h04, 1'b0}, 400);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0}, 401);
      step(vec_t'{1'b1, 8'h04, 8'hFF, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 1'b1}, 402);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1}, 403);
      step(vec_t'{1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0}, 404);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d entries exp 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_capture_ctrl.md
Name: irq_capture_ctrl

Overview:
Interrupt-request capture and presentation stage that sits directly upstream of the 8-to-3 priority encoder. It captures request events into a pending register and applies an enable mask. The highest-index enabled pending request is presented as an encoded ID over a valid/ready handshake. Accepting an ID clears its pending bit. This turns the purely combinational encoder function into a stable, backpressure-aware request source for a sequential consumer.

Parameters:
N, 8, number of request lines
W, 3, ID width (log2 N)
EDGE, 1, 1 = capture rising edges of req_in; 0 = capture level (any cycle req_in bit is high)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req_in  input  N  raw request lines, already synchronous to clk
mask  input  N  per-line enable, 1 = eligible for presentation
irq_ready  input  1  consumer accepts the presented ID
ovf_clr  input  1  clears the sticky overflow flag
irq_valid  output  1  irq_id is valid
irq_id  output  W  encoded index of the presented request
pending  output  N  current pending register
overflow  output  1  sticky: a request re-arrived while its bit was still pending

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (rst_n=0 at an edge) forces the following to 0:
  - req_q, pending, irq_valid, irq_id, overflow
  - FSM state to IDLE
  - Reset mid-handshake drops irq_valid on that edge and discards all pending requests.
- Edge detect:
  - req_q <= req_in every cycle.
  - set_vec = EDGE ? (req_in & ~req_q) : req_in.
  - A line held high across reset release counts as a rising edge on the first active cycle.
- Pending update: pending <= (pending & ~clr_vec) | set_vec.
  - clr_vec is one-hot of irq_id when irq_valid & irq_ready, else 0.
  - Set wins over clear on the same bit in the same cycle; the bit stays pending.
- Eligibility: elig = pending & mask, using registered pending. Highest set index has priority (bit N-1 highest), matching the downstream encoder.
- FSM IDLE:
  - If elig != 0, load irq_id = highest index of elig, assert irq_valid next edge, go to PRESENT.
  - Otherwise stay in IDLE; irq_valid=0 and irq_id holds its last value.
- FSM PRESENT:
  - irq_valid=1. irq_id and irq_valid are held stable until irq_ready=1. No retraction, even if mask drops the bit or a higher-priority request arrives.
  - On irq_valid & irq_ready: clear the pending bit, deassert irq_valid on the same edge, return to IDLE.
- Latency:
  - req_in rising edge sampled at edge t sets pending after edge t.
  - irq_valid rises after edge t+1 (2 cycles from req_in change).
  - Minimum grant spacing is 2 cycles (one IDLE bubble after each accept).
- Overflow:
  - Set when any set_vec bit hits a pending bit that is 1 and not cleared that cycle.
  - Sticky until ovf_clr=1. If ovf_clr and a new overflow event occur in the same cycle, overflow stays 1 (set wins).
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req_in=8'hFF, mask=8'hFF -> irq_valid=0, irq_id=0, pending=8'h00, overflow=0. After release -> pending=8'hFF one cycle later, irq_valid=1 with irq_id=7 the next cycle.
- Single request: mask=8'hFF, irq_ready=1, 1-cycle pulse on req_in[3] -> pending=8'h08 after 1 edge; irq_valid=1, irq_id=3 after 2 edges; accepted; pending=8'h00, irq_valid=0 after 3 edges.
- Priority order: req_in steps 8'h00 -> 8'b1001_0100 in one cycle, irq_ready=1 -> IDs presented 7, 4, 2, two cycles apart, then pending=8'h00.
- Masking: mask=8'h7F, rising edges on bits 7 and 1 -> only ID 1 presented, pending=8'h80 afterwards. Then mask=8'hFF -> ID 7 presented 1 cycle later.
- Backpressure/stability: irq_ready=0, ID 5 presented, then rising edge on bit 6 -> irq_id stays 5, pending=8'h60. irq_ready=1 -> 5 accepted, then ID 6 presented.
- Overflow and set-vs-clear: bit 2 pending and unaccepted, second rising edge on bit 2 -> overflow=1. ovf_clr=1 for 1 cycle -> overflow=0. Rising edge on bit 4 in the same cycle its ID 4 is accepted -> pending[4] remains 1 and ID 4 is re-presented.
